// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the datapath and the memory responder.
//   WORD_W  : data word width used by the datapath registers and the RAM
//   CNT_W   : width of the wait-state down-counter (max 15 wait states)
//   state_t : memory responder FSM encoding
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage : cpu_defs

// File: rtl/memory_ram.sv
// ---------------------------------------------------------------------------
// memory_ram
// Word-addressed single-port synchronous RAM, 2^ADDR_W words of WORD_W bits.
// Contents are not reset. dout is registered and only updates on a read
// strobe, so it keeps the last read word across writes and idle cycles.
//   clock : rising-edge clock
//   we    : write strobe, stores din at addr
//   re    : read strobe, loads dout from addr
//   addr  : word address
//   din   : write data
//   dout  : registered read data
// ---------------------------------------------------------------------------
module memory_ram
    import cpu_defs::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clock,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= din;
        end
        if (re) begin
            dout <= mem[addr];
        end
    end

endmodule : memory_ram

// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
// Memory-side responder for the MAR/MDR interface. Latches a read or write
// request, waits WAIT_STATES cycles, performs one access on the internal RAM
// and completes with a four-phase Read/Write - Done handshake.
//   clock   : system clock, rising edge
//   clear   : asynchronous active-high reset
//   Read    : read request level, held until Done
//   Write   : write request level, held until Done
//   address : word address from MAR
//   data_in : write data from MDR
//   Mdatain : read data towards the MDR input mux
//   Done    : access complete, held until both requests drop
//   Busy    : FSM not idle
//   err     : one-cycle pulse on an illegal request
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for exactly one of Read/Write
// WAIT    | counting wait states; access happens on the edge leaving WAIT
// RELEASE | access finished (or rejected); waiting for Read=Write=0
// ---------------------------------------------------------------------------
module memory_responder
    import cpu_defs::*;
#(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] Mdatain,
    output logic              Done,
    output logic              Busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

    state_t             state,    state_nxt;
    logic [CNT_W-1:0]   cnt,      cnt_nxt;
    logic [ADDR_W-1:0]  lat_addr, lat_addr_nxt;
    logic [WORD_W-1:0]  lat_data, lat_data_nxt;
    logic               lat_rd,   lat_rd_nxt;
    logic               lat_oob,  lat_oob_nxt;
    logic               done_r,   done_nxt;
    logic               err_r,    err_nxt;
    // Selects RAM read data onto Mdatain; cleared by reset and by an
    // out-of-range read so that Mdatain reads as zero in those cases.
    logic               mdat_sel, mdat_sel_nxt;

    logic               ram_we;
    logic               ram_re;
    logic [WORD_W-1:0]  ram_dout;
    logic               addr_oob;

    assign addr_oob = |address[WORD_W-1:ADDR_W];

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_rd   <= 1'b0;
            lat_oob  <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            mdat_sel <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            lat_addr <= lat_addr_nxt;
            lat_data <= lat_data_nxt;
            lat_rd   <= lat_rd_nxt;
            lat_oob  <= lat_oob_nxt;
            done_r   <= done_nxt;
            err_r    <= err_nxt;
            mdat_sel <= mdat_sel_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        lat_addr_nxt = lat_addr;
        lat_data_nxt = lat_data;
        lat_rd_nxt   = lat_rd;
        lat_oob_nxt  = lat_oob;
        done_nxt     = done_r;
        err_nxt      = 1'b0;
        mdat_sel_nxt = mdat_sel;
        ram_we       = 1'b0;
        ram_re       = 1'b0;

        case (state)
            IDLE: begin
                if (Read ^ Write) begin
                    lat_addr_nxt = address[ADDR_W-1:0];
                    lat_data_nxt = data_in;
                    lat_rd_nxt   = Read;
                    lat_oob_nxt  = addr_oob;
                    cnt_nxt      = WAIT_CNT;
                    state_nxt    = WAIT;
                end else if (Read && Write) begin
                    // Ambiguous request: reject without touching the RAM and
                    // park in RELEASE until the requester backs off.
                    err_nxt   = 1'b1;
                    state_nxt = RELEASE;
                end
            end

            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    if (lat_oob) begin
                        err_nxt = 1'b1;
                        if (lat_rd) begin
                            mdat_sel_nxt = 1'b0;
                        end
                    end else if (lat_rd) begin
                        ram_re       = 1'b1;
                        mdat_sel_nxt = 1'b1;
                    end else begin
                        ram_we = 1'b1;
                    end
                    done_nxt  = 1'b1;
                    state_nxt = RELEASE;
                end
            end

            RELEASE: begin
                if (!Read && !Write) begin
                    done_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                done_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    memory_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (lat_addr),
        .din   (lat_data),
        .dout  (ram_dout)
    );

    assign Mdatain = mdat_sel ? ram_dout : '0;
    assign Done    = done_r;
    assign Busy    = (state != IDLE);
    assign err     = err_r;

endmodule : memory_responder
